stream_mux_rr: RTL



---
 rtl/stream_mux_rr.sv | 88 ++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux with fixed-select or round-robin grant
// and a single registered output stage tagged with the source channel.
module stream_mux_rr #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_ch
);
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hi_vld, lo_vld, fix_vld, gnt_vld, load_en, xfer;
  logic [SEL_W-1:0] hi_g, lo_g, fix_g, gnt;
  logic [W-1:0]     gnt_data;
  // Round-robin: lowest valid channel above rr_ptr wins, else lowest at or below it.
  always_comb begin
    hi_vld  = 1'b0;
    hi_g    = '0;
    lo_vld  = 1'b0;
    lo_g    = '0;
    fix_vld = 1'b0;
    fix_g   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k] && SEL_W'(k) > rr_ptr_q) begin
        hi_vld = 1'b1;
        hi_g   = SEL_W'(k);
      end
      if (in_valid[k] && SEL_W'(k) <= rr_ptr_q) begin
        lo_vld = 1'b1;
        lo_g   = SEL_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (SEL_W'(k) == sel && in_valid[k]) begin
        fix_vld = 1'b1;
        fix_g   = SEL_W'(k);
      end
    end
    gnt_vld = mode ? (hi_vld || lo_vld) : fix_vld;
    gnt     = mode ? (hi_vld ? hi_g : lo_g) : fix_g;
  end
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (SEL_W'(k) == gnt) gnt_data = in_data[k*W +: W];
    end
  end
  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && gnt_vld;
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) in_ready[k] = xfer && (gnt == SEL_W'(k));
  end
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = xfer ? gnt_data : out_data_q;
    out_ch_d    = xfer ? gnt : out_ch_q;
    rr_ptr_d    = xfer ? gnt : rr_ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule
